gray_updown_counter: RTL and testbench

Parametrised up/down Gray-code counter. It extends the plain up-counting Gray counter with direction control, synchronous clear, parallel load, a wrap/saturate mode, a binary-coded shadow output and boundary flags. It serves as the pointer and sequence-number source for clock-domain-crossing FIFOs and multi-rate position counters. The Gray output is the only output intended for crossing domains.

---
 rtl/gray_updown_counter.sv | 131 +++++++++++++
 tb/tb_gray_updown_counter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_updown_counter.sv
// ---------------------------------------------------------------------------
// gray_updown_counter
//
// Parametrised up/down Gray-code counter with a binary-coded shadow value.
// It is meant to be the pointer or sequence-number source for clock-domain-
// crossing FIFOs and multi-rate position counters. Only gray_count is
// intended to cross clock domains. Every counting step changes exactly one
// bit of gray_count, and that includes the step that wraps around.
//
// Parameters:
//   WIDTH     counter width in bits (2..32)
//   SATURATE  0 = wrap at the ends of the range, 1 = hold at the ends
//   RESET_VAL binary value taken while aclr is high
//
// Ports:
//   clk        rising-edge clock
//   aclr       asynchronous reset, active-high; outputs hold while high
//   ena        count enable, one step per clk edge while high
//   up         direction, 1 = increment, 0 = decrement (sampled with ena)
//   sclr       synchronous clear to binary 0 (highest priority)
//   load       synchronous parallel load of load_val
//   load_val   binary value for load
//   gray_count registered Gray-coded count
//   bin_count  registered binary count, same cycle as gray_count
//   at_max     registered, high when bin_count is all ones
//   at_min     registered, high when bin_count is zero
//   wrap       registered one-cycle pulse on a wrap-around step
// ---------------------------------------------------------------------------
module gray_updown_counter #(
   parameter int unsigned      WIDTH     = 8,
   parameter bit               SATURATE  = 1'b0,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             aclr,
   input  logic             ena,
   input  logic             up,
   input  logic             sclr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] gray_count,
   output logic [WIDTH-1:0] bin_count,
   output logic             at_max,
   output logic             at_min,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL    = '1;
   localparam logic [WIDTH-1:0] ZERO_VAL   = '0;
   localparam logic [WIDTH-1:0] ONE_VAL    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);

   function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   logic [WIDTH-1:0] bin_inc;
   logic [WIDTH-1:0] bin_dec;
   logic             at_top_end;
   logic             at_bottom_end;
   logic             step_hits_end;
   logic [WIDTH-1:0] step_val;
   logic             step_wraps;
   logic [WIDTH-1:0] next_bin;
   logic [WIDTH-1:0] next_gray;
   logic             next_wrap;
   logic             next_at_max;
   logic             next_at_min;

   // The modular increment/decrement already produces the wrapped value
   // (max + 1 -> 0, 0 - 1 -> max), so wrap mode needs no special case for
   // the value, only for the pulse. Saturate mode substitutes the current
   // value when the step would leave the range.
   always_comb begin
      bin_inc       = bin_count + ONE_VAL;
      bin_dec       = bin_count - ONE_VAL;
      at_top_end    = (bin_count == MAX_VAL);
      at_bottom_end = (bin_count == ZERO_VAL);
      step_hits_end = up ? at_top_end : at_bottom_end;
      step_val      = bin_count;
      step_wraps    = 1'b0;
      if (step_hits_end && SATURATE) begin
         step_val   = bin_count;
         step_wraps = 1'b0;
      end else begin
         step_val   = up ? bin_inc : bin_dec;
         step_wraps = step_hits_end;
      end
   end

   // Command priority: sclr, then load, then a counting step, else hold.
   // The wrap pulse can only come from a counting step.
   always_comb begin
      next_bin  = bin_count;
      next_wrap = 1'b0;
      if (sclr) begin
         next_bin = ZERO_VAL;
      end else if (load) begin
         next_bin = load_val;
      end else if (ena) begin
         next_bin  = step_val;
         next_wrap = step_wraps;
      end
   end

   // Both registers and the boundary flags come from one next-state value,
   // so the Gray and binary views can never disagree and the flags are
   // exact on the same cycle as the count.
   always_comb begin
      next_gray   = to_gray(next_bin);
      next_at_max = (next_bin == MAX_VAL);
      next_at_min = (next_bin == ZERO_VAL);
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         bin_count  <= RESET_VAL;
         gray_count <= RESET_GRAY;
         at_max     <= (RESET_VAL == MAX_VAL);
         at_min     <= (RESET_VAL == ZERO_VAL);
         wrap       <= 1'b0;
      end else begin
         bin_count  <= next_bin;
         gray_count <= next_gray;
         at_max     <= next_at_max;
         at_min     <= next_at_min;
         wrap       <= next_wrap;
      end
   end

endmodule

// File: tb/tb_gray_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_gray_updown_counter
//
// Drives three counter configurations from one shared set of inputs:
//   inst 0: WIDTH=8, wrap mode,     RESET_VAL=0
//   inst 1: WIDTH=4, wrap mode,     RESET_VAL=5
//   inst 2: WIDTH=4, saturate mode, RESET_VAL=0
// Stimulus pushes the reference model's expected state into a queue; a
// separate monitor pops one entry per clk edge (or per asynchronous reset
// probe) and compares every output of every instance.
// ---------------------------------------------------------------------------
module tb_gray_updown_counter;

   typedef struct packed {
      logic [2:0][7:0] bin;
      logic [2:0]      wrp;
      logic [2:0]      step;
   } exp_t;

   logic       clk = 1'b0;
   logic       aclr = 1'b0;
   logic       ena = 1'b0;
   logic       up = 1'b0;
   logic       sclr = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = '0;
   logic       probe = 1'b0;
   bit         started = 1'b0;

   logic [7:0] gray8, bin8;
   logic [3:0] gray4w, bin4w, gray4s, bin4s;
   logic [2:0] act_max, act_min, act_wrap;

   exp_t expQ[$];
   int   mBin[3];
   int   nChecks = 0;
   int   nFails  = 0;

   always #5 clk = ~clk;

   gray_updown_counter #(.WIDTH(8), .SATURATE(1'b0), .RESET_VAL(8'd0)) dut8 (
      .clk(clk), .aclr(aclr), .ena(ena), .up(up), .sclr(sclr), .load(load),
      .load_val(load_val), .gray_count(gray8), .bin_count(bin8),
      .at_max(act_max[0]), .at_min(act_min[0]), .wrap(act_wrap[0]));

   gray_updown_counter #(.WIDTH(4), .SATURATE(1'b0), .RESET_VAL(4'd5)) dut4w (
      .clk(clk), .aclr(aclr), .ena(ena), .up(up), .sclr(sclr), .load(load),
      .load_val(load_val[3:0]), .gray_count(gray4w), .bin_count(bin4w),
      .at_max(act_max[1]), .at_min(act_min[1]), .wrap(act_wrap[1]));

   gray_updown_counter #(.WIDTH(4), .SATURATE(1'b1), .RESET_VAL(4'd0)) dut4s (
      .clk(clk), .aclr(aclr), .ena(ena), .up(up), .sclr(sclr), .load(load),
      .load_val(load_val[3:0]), .gray_count(gray4s), .bin_count(bin4s),
      .at_max(act_max[2]), .at_min(act_min[2]), .wrap(act_wrap[2]));

   // Configuration of each instance as seen by the reference model
   function automatic int maxOf(input int k);
      return (k == 0) ? 255 : 15;
   endfunction

   function automatic bit satOf(input int k);
      return (k == 2);
   endfunction

   function automatic int resetOf(input int k);
      return (k == 1) ? 5 : 0;
   endfunction

   function automatic int grayOf(input int b);
      return b ^ (b >> 1);
   endfunction

   // Reference model: advance all instances by one edge and return the
   // expected post-edge state. Counting is plain integer arithmetic; a
   // result outside 0..max is a wrap (or a held boundary in saturate mode).
   function automatic exp_t modelStep(input bit a, input bit s, input bit l,
                                      input bit e, input bit u, input int lv);
      exp_t r;
      r = '0;
      for (int k = 0; k < 3; k++) begin
         int t;
         if (a) begin
            mBin[k] = resetOf(k);
         end else if (s) begin
            mBin[k] = 0;
         end else if (l) begin
            mBin[k] = lv % (maxOf(k) + 1);
         end else if (e) begin
            t = u ? mBin[k] + 1 : mBin[k] - 1;
            if (t > maxOf(k) || t < 0) begin
               if (!satOf(k)) begin
                  mBin[k]  = (t < 0) ? maxOf(k) : 0;
                  r.wrp[k]  = 1'b1;
                  r.step[k] = 1'b1;
               end
            end else begin
               mBin[k]   = t;
               r.step[k] = 1'b1;
            end
         end
         r.bin[k] = 8'(mBin[k]);
      end
      return r;
   endfunction

   task automatic applyStimulus(input bit a, input bit s, input bit l,
                                input bit e, input bit u, input logic [7:0] lv);
      @(negedge clk);
      aclr     = a;
      sclr     = s;
      load     = l;
      ena      = e;
      up       = u;
      load_val = lv;
      expQ.push_back(modelStep(a, s, l, e, u, int'(lv)));
      started = 1'b1;
   endtask

   // Asserts aclr between clk edges and requests an immediate check, so the
   // outputs must change without any clock edge.
   task automatic asyncReset();
      @(posedge clk);
      #3;
      aclr = 1'b1;
      expQ.push_back(modelStep(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0));
      probe = 1'b1;
      #1;
      probe = 1'b0;
   endtask

   task automatic checkOutput(input string name, input int k, input int act,
                              input int expv);
      nChecks++;
      if (act != expv) begin
         nFails++;
         $display("[TB] FAIL %s inst%0d at %0t: got %0h expected %0h",
                  name, k, $time, act, expv);
      end
   endtask

   // Monitor: one expectation per clk edge or asynchronous-reset probe
   initial begin : monitor
      logic [2:0][7:0] actBin, actGray, prevGray;
      exp_t e;
      prevGray = '0;
      forever begin
         @(posedge clk or posedge probe);
         #1;
         actBin[0]  = bin8;
         actBin[1]  = {4'b0, bin4w};
         actBin[2]  = {4'b0, bin4s};
         actGray[0] = gray8;
         actGray[1] = {4'b0, gray4w};
         actGray[2] = {4'b0, gray4s};
         if (expQ.size() == 0) begin
            if (started) begin
               nChecks++;
               nFails++;
               $display("[TB] FAIL scoreboard_underflow at %0t: got 0 entries expected 1",
                        $time);
            end
         end else begin
            e = expQ.pop_front();
            for (int k = 0; k < 3; k++) begin
               checkOutput("bin_count", k, int'(actBin[k]), int'(e.bin[k]));
               checkOutput("gray_count", k, int'(actGray[k]), grayOf(int'(e.bin[k])));
               checkOutput("at_max", k, int'(act_max[k]),
                           (int'(e.bin[k]) == maxOf(k)) ? 1 : 0);
               checkOutput("at_min", k, int'(act_min[k]),
                           (e.bin[k] == 8'd0) ? 1 : 0);
               checkOutput("wrap", k, int'(act_wrap[k]), int'(e.wrp[k]));
               if (e.step[k])
                  checkOutput("gray_one_bit_step", k,
                              $countones(actGray[k] ^ prevGray[k]), 1);
               prevGray[k] = actGray[k];
            end
         end
      end
   end

   initial begin : stimulus
      // Reset asserted shortly after time zero and checked with no clk edge
      #1;
      aclr = 1'b1;
      expQ.push_back(modelStep(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0));
      probe = 1'b1;
      #1;
      probe = 1'b0;

      // Edges during reset change nothing, even with ena high
      applyStimulus(1, 0, 0, 1, 1, 8'h00);
      applyStimulus(1, 0, 0, 1, 1, 8'h00);

      // Clear, then a full 4-bit up-count lap including the wrap step
      applyStimulus(0, 1, 0, 0, 0, 8'h00);
      for (int i = 0; i < 17; i++)
         applyStimulus(0, 0, 0, 1, 1, 8'h00);

      // Down from zero: wrap to max, then an ordinary step
      applyStimulus(0, 1, 0, 0, 0, 8'h00);
      applyStimulus(0, 0, 0, 1, 0, 8'h00);
      applyStimulus(0, 0, 0, 1, 0, 8'h00);

      // Load near the top, push up against the end, then down past zero
      applyStimulus(0, 0, 1, 0, 0, 8'h0E);
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 0, 0, 1, 1, 8'h00);
      for (int i = 0; i < 16; i++)
         applyStimulus(0, 0, 0, 1, 0, 8'h00);

      // Priority: sclr over load over ena, then load over ena
      applyStimulus(0, 1, 1, 1, 1, 8'h09);
      applyStimulus(0, 0, 1, 1, 1, 8'h09);

      // Direction toggling returns to the starting value
      applyStimulus(0, 0, 0, 1, 1, 8'h00);
      applyStimulus(0, 0, 0, 1, 0, 8'h00);

      // Reset mid-operation: count inst1 from 5 to 11, then async reset
      asyncReset();
      applyStimulus(0, 0, 0, 1, 1, 8'h00);
      for (int i = 0; i < 5; i++)
         applyStimulus(0, 0, 0, 1, 1, 8'h00);
      asyncReset();
      applyStimulus(1, 0, 0, 1, 1, 8'h00);
      applyStimulus(1, 0, 0, 1, 1, 8'h00);
      applyStimulus(0, 0, 0, 1, 1, 8'h00);

      // Random regression
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            asyncReset();
            applyStimulus(1, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom));
         end else begin
            applyStimulus(0,
                          ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)),
                          8'($urandom));
         end
      end

      applyStimulus(0, 0, 0, 0, 0, 8'h00);
      @(posedge clk);
      #3;
      checkOutput("scoreboard_drained", 0, expQ.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
